pm_readout_seq: RTL and testbench
=================================

PM_READOUT_SEQ -- requirements
Module: pm_readout_seq

Interface
REQ-001 Parameter Nti, 16, number of time-interleaved ADC slices; taken from const_pack.
REQ-002 Parameter Npm, 20, phase-monitor word width; matches the pm_out width of the analog core.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 abort  input  1  terminates the sweep; takes priority over every other input except rst.
REQ-007 slice_mask  input  Nti  slices to measure; bit i selects slice i.
REQ-008 settle_cycles  input  8  en_pm settle time in cycles; the value 0 is treated as 1.
REQ-009 n_avg_log2  input  3  log2 of the number of samples averaged per slice (1..128).
REQ-010 pm_out  input  Npm x Nti (unpacked [Nti-1:0])  phase-monitor counts from the analog core.
REQ-011 en_pm  output  Nti  phase-monitor enable to the analog core; at most one bit set.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse marking sweep completion.
REQ-014 result_valid  output  1  result_idx and result_data are valid.
REQ-015 result_ready  input  1  consumer accepts the result; the transfer occurs when valid and ready are both high.
REQ-016 result_idx  output  $clog2(Nti)  slice index of the current result.
REQ-017 result_data  output  Npm  averaged phase-monitor value.

Function
REQ-018 The FSM states SHALL be IDLE, SETTLE, ACCUM and RESULT.
REQ-019 On start in IDLE, the block SHALL latch slice_mask, settle_cycles and n_avg_log2; later changes to these inputs SHALL have no effect until the next start.
REQ-020 Start with a latched mask of 0 SHALL give done=1 on the next cycle, no results, and a stay in IDLE.
REQ-021 Start with a nonzero mask SHALL move the FSM to SETTLE on the next cycle, with idx set to the lowest set mask bit.
REQ-022 In SETTLE, en_pm SHALL be one-hot at idx for max(settle_cycles,1) cycles, after which the FSM SHALL enter ACCUM with the accumulator cleared.
REQ-023 In ACCUM, en_pm SHALL stay one-hot at idx.
REQ-024 In ACCUM, the block SHALL add pm_out[idx] (zero-extended) into a (Npm+7)-bit accumulator on each of exactly 2^n_avg_log2 consecutive cycles; the accumulator SHALL never overflow.
REQ-025 After the last ACCUM cycle the FSM SHALL enter RESULT, with result_data = accumulator >> n_avg_log2 (truncating), result_idx = idx, result_valid=1 and en_pm=0.
REQ-026 result_idx and result_data SHALL stay stable while result_valid=1 and result_ready=0.
REQ-027 On a RESULT handshake with a higher set mask bit remaining, the FSM SHALL go to SETTLE for the next set bit on the next cycle.
REQ-028 On a RESULT handshake with no higher set mask bit remaining, the FSM SHALL go to IDLE, with done=1 for one cycle and busy=0 in that same cycle.
REQ-029 abort in any non-IDLE state SHALL return the FSM to IDLE on the next cycle, with en_pm=0, result_valid=0 and no done pulse.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 start and abort asserted together in IDLE SHALL behave as abort, so no sweep begins.
REQ-033 A slice with mask bit Nti-1 set SHALL be the last one processed; the slice index SHALL not wrap.
REQ-034 pm_out SHALL be sampled directly without a synchronizer; pm_out is quasi-static while en_pm is held.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While rst=1, the state SHALL be IDLE and en_pm, busy, done, result_valid, result_idx, result_data, the accumulator and the latched configuration SHALL all be 0.
REQ-037 Deassertion of rst SHALL need no start-up cycles; start is honoured on the first clock edge after rst falls.
REQ-038 rst asserted mid-sweep SHALL clear all outputs immediately, without waiting for a clock edge.

Verification
REQ-039 mask=0x0001, settle=4, n=0, ready held 1, pm_out[0]=0x12345, start at t0 -> en_pm=0x0001 on t1..t5; result_valid at t6 with idx=0 and data=0x12345; done=1 and busy=0 at t7.
REQ-040 mask=0x8005, settle=0, n=2, pm_out[i]=i*0x100 -> results arrive in order idx 0, 2, 15 with data 0x000, 0x200, 0xF00; each SETTLE lasts 1 cycle and each ACCUM lasts 4 cycles; exactly one done pulse.
REQ-041 n=7, pm_out[3]=0xFFFFF, mask=0x0008 -> result_data=0xFFFFF, with no overflow in the 27-bit accumulator.
REQ-042 result_ready held 0 for 10 cycles in RESULT -> result_valid, result_idx and result_data stay constant and en_pm stays 0; a later ready=1 completes the handshake.
REQ-043 abort during ACCUM of slice 2 -> next cycle IDLE with en_pm=0 and no done; a following start with mask=0 -> done pulse one cycle later.
REQ-044 rst pulsed asynchronously mid-SETTLE -> all outputs 0 before the next clock edge; a start on the first edge after rst falls is accepted.

Source files
------------

// File: rtl/pm_readout_seq_if.sv
// pm_readout_seq_if
//   Bundles the sweep control, configuration, analog-core and result
//   signals of the phase-monitor readout sequencer.
//
//   Result handshake: result_valid is raised by the sequencer with
//   result_idx/result_data held stable until a cycle in which both
//   result_valid and result_ready are high; that clock edge is the
//   transfer. result_valid never depends combinationally on result_ready.
//
//   master : sweep requester / analog-core side (drives start, abort,
//            configuration, pm_out, result_ready)
//   slave  : the sequencer (drives en_pm, busy, done and the result)
interface pm_readout_seq_if #(
    parameter int Nti = 16,
    parameter int Npm = 20
);
    localparam int IDX_W = (Nti > 1) ? $clog2(Nti) : 1;

    logic                 start;
    logic                 abort;
    logic [Nti-1:0]       slice_mask;
    logic [7:0]           settle_cycles;
    logic [2:0]           n_avg_log2;
    logic [Npm-1:0]       pm_out [Nti-1:0];
    logic [Nti-1:0]       en_pm;
    logic                 busy;
    logic                 done;
    logic                 result_valid;
    logic                 result_ready;
    logic [IDX_W-1:0]     result_idx;
    logic [Npm-1:0]       result_data;

    modport master (
        output start, abort, slice_mask, settle_cycles, n_avg_log2, pm_out,
               result_ready,
        input  en_pm, busy, done, result_valid, result_idx, result_data
    );

    modport slave (
        input  start, abort, slice_mask, settle_cycles, n_avg_log2, pm_out,
               result_ready,
        output en_pm, busy, done, result_valid, result_idx, result_data
    );
endinterface

// File: rtl/pm_readout_seq.sv
// pm_readout_seq
//   Sweeps the phase monitor across the selected ADC slices. For each set
//   bit of the latched slice mask (lowest index first) it enables the
//   slice's phase monitor, waits a settle time, averages 2^n samples of
//   pm_out for that slice and presents the average as a result.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   sweep        : pm_readout_seq_if.slave (start/abort, configuration,
//                  pm_out, en_pm, busy, done, result handshake)
//   dbg_state_o  : current FSM state (0 IDLE, 1 SETTLE, 2 ACCUM, 3 RESULT)
module pm_readout_seq #(
    parameter int Nti = 16,
    parameter int Npm = 20
) (
    input  logic             clk,
    input  logic             rst,
    pm_readout_seq_if.slave  sweep,
    output logic [1:0]       dbg_state_o
);
    localparam int IDX_W = (Nti > 1) ? $clog2(Nti) : 1;
    // 7 guard bits: up to 128 full-scale samples cannot overflow.
    localparam int ACC_W = Npm + 7;
    localparam logic [Nti-1:0] ONE_HOT0 = Nti'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [Nti-1:0]     mask_q;
    logic [7:0]         settle_q;
    logic [2:0]         navg_q;
    logic [7:0]         cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [Nti-1:0]     en_pm_q;
    logic               busy_q;
    logic               done_q;
    logic               result_valid_q;
    logic [IDX_W-1:0]   result_idx_q;
    logic [Npm-1:0]     result_data_q;

    logic               first_found_d;
    logic [IDX_W-1:0]   first_idx_d;
    logic               next_found_d;
    logic [IDX_W-1:0]   next_idx_d;
    logic [ACC_W-1:0]   acc_d;
    logic [7:0]         start_settle_d;
    logic [7:0]         next_settle_d;
    logic [7:0]         accum_cnt_d;

    // Lowest set bit of the incoming mask (used at start) and the lowest
    // set bit of the latched mask strictly above the current slice.
    // Scanning downwards lets the lowest match overwrite higher ones.
    always_comb begin
        first_found_d = 1'b0;
        first_idx_d   = '0;
        next_found_d  = 1'b0;
        next_idx_d    = '0;
        for (int i = Nti - 1; i >= 0; i--) begin
            if (sweep.slice_mask[i]) begin
                first_found_d = 1'b1;
                first_idx_d   = IDX_W'(i);
            end
            if (mask_q[i] && (i > int'(idx_q))) begin
                next_found_d = 1'b1;
                next_idx_d   = IDX_W'(i);
            end
        end
    end

    assign acc_d = acc_q + ACC_W'(sweep.pm_out[idx_q]);

    // Counters hold "cycles remaining minus one"; a settle of 0 behaves as 1.
    assign start_settle_d = (sweep.settle_cycles == 8'd0) ? 8'd0
                                                          : sweep.settle_cycles - 8'd1;
    assign next_settle_d  = (settle_q == 8'd0) ? 8'd0 : settle_q - 8'd1;
    assign accum_cnt_d    = (8'd1 << navg_q) - 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            mask_q         <= '0;
            settle_q       <= '0;
            navg_q         <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            en_pm_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_idx_q   <= '0;
            result_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (sweep.abort) begin
                // Abort wins over start; in IDLE it changes nothing.
                if (state_q != IDLE) begin
                    state_q        <= IDLE;
                    en_pm_q        <= '0;
                    busy_q         <= 1'b0;
                    result_valid_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (sweep.start) begin
                            mask_q   <= sweep.slice_mask;
                            settle_q <= sweep.settle_cycles;
                            navg_q   <= sweep.n_avg_log2;
                            if (first_found_d) begin
                                state_q <= SETTLE;
                                idx_q   <= first_idx_d;
                                en_pm_q <= ONE_HOT0 << first_idx_d;
                                busy_q  <= 1'b1;
                                cnt_q   <= start_settle_d;
                            end else begin
                                // Empty sweep completes immediately.
                                done_q <= 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= ACCUM;
                            acc_q   <= '0;
                            cnt_q   <= accum_cnt_d;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    ACCUM: begin
                        acc_q <= acc_d;
                        if (cnt_q == 8'd0) begin
                            state_q        <= RESULT;
                            en_pm_q        <= '0;
                            result_valid_q <= 1'b1;
                            result_idx_q   <= idx_q;
                            result_data_q  <= Npm'(acc_d >> navg_q);
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    RESULT: begin
                        if (sweep.result_ready) begin
                            result_valid_q <= 1'b0;
                            if (next_found_d) begin
                                state_q <= SETTLE;
                                idx_q   <= next_idx_d;
                                en_pm_q <= ONE_HOT0 << next_idx_d;
                                cnt_q   <= next_settle_d;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sweep.en_pm        = en_pm_q;
    assign sweep.busy         = busy_q;
    assign sweep.done         = done_q;
    assign sweep.result_valid = result_valid_q;
    assign sweep.result_idx   = result_idx_q;
    assign sweep.result_data  = result_data_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_pm_readout_seq.sv
// tb_pm_readout_seq
//   Directed bench for pm_readout_seq: reset values, single-slice timing,
//   multi-slice ordering, large averaging, back-pressure, abort and
//   asynchronous reset. Expected results are queued when a sweep is
//   launched and popped by a monitor on each result transfer.
module tb_pm_readout_seq;
    localparam int NTI = 16;
    localparam int NPM = 20;
    localparam int IDX_W = 4;
    localparam logic [31:0] ST_IDLE   = 32'd0;
    localparam logic [31:0] ST_SETTLE = 32'd1;
    localparam logic [31:0] ST_ACCUM  = 32'd2;
    localparam logic [31:0] ST_RESULT = 32'd3;

    logic clk;
    logic rst;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [IDX_W+NPM-1:0] exp_q[$];

    pm_readout_seq_if #(.Nti(NTI), .Npm(NPM)) sweep ();

    pm_readout_seq #(.Nti(NTI), .Npm(NPM)) dut (
        .clk         (clk),
        .rst         (rst),
        .sweep       (sweep),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference average: accumulate 2^n identical samples, then shift.
    function automatic logic [IDX_W+NPM-1:0] model(input int idx, input logic [NPM-1:0] pm,
                                                   input int n);
        logic [NPM+6:0] sum;
        logic [NPM+6:0] avg;
        logic [IDX_W-1:0] i4;
        sum = '0;
        for (int k = 0; k < (1 << n); k++) sum = sum + {7'd0, pm};
        avg = sum >> n;
        i4 = IDX_W'(idx);
        return {i4, avg[NPM-1:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cfg(input logic [NTI-1:0] mask, input logic [7:0] settle,
                             input logic [2:0] n);
        sweep.slice_mask    = mask;
        sweep.settle_cycles = settle;
        sweep.n_avg_log2    = n;
    endtask

    task automatic pulse_start();
        sweep.start = 1'b1;
        cyc();
        sweep.start = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && sweep.result_valid && sweep.result_ready) begin
            chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("result_idx_data", 32'({sweep.result_idx, sweep.result_data}),
                    32'(exp_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int settle_n, accum_n, done_n, onehot_bad;
        logic seen;

        rst = 1'b1;
        sweep.start = 1'b0;
        sweep.abort = 1'b0;
        sweep.result_ready = 1'b1;
        drive_cfg('0, 8'd0, 3'd0);
        for (int i = 0; i < NTI; i++) sweep.pm_out[i] = '0;

        // Reset values
        #12;
        chk("rst_state", 32'(dbg_state), ST_IDLE);
        chk("rst_en_pm", 32'(sweep.en_pm), 32'd0);
        chk("rst_busy", 32'(sweep.busy), 32'd0);
        chk("rst_done", 32'(sweep.done), 32'd0);
        chk("rst_valid", 32'(sweep.result_valid), 32'd0);
        chk("rst_idx_data", 32'({sweep.result_idx, sweep.result_data}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        // Single slice, settle 4, n=0
        sweep.pm_out[0] = 20'h12345;
        drive_cfg(16'h0001, 8'd4, 3'd0);
        exp_q.push_back(model(0, 20'h12345, 0));
        pulse_start();
        chk("t1_state", 32'(dbg_state), ST_SETTLE);
        chk("t1_busy", 32'(sweep.busy), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            chk("t1_en_pm", 32'(sweep.en_pm), 32'h0001);
            cyc();
        end
        chk("t1_valid", 32'(sweep.result_valid), 32'd1);
        chk("t1_res_en_pm", 32'(sweep.en_pm), 32'd0);
        chk("t1_data", 32'(sweep.result_data), 32'h12345);
        cyc();
        chk("t1_done", 32'(sweep.done), 32'd1);
        chk("t1_busy_end", 32'(sweep.busy), 32'd0);
        chk("t1_valid_end", 32'(sweep.result_valid), 32'd0);
        cyc();
        chk("t1_done_single", 32'(sweep.done), 32'd0);

        // Mask 0x8005, settle 0, n=2; config changes and start while busy ignored
        for (int i = 0; i < NTI; i++) sweep.pm_out[i] = NPM'(i * 32'h100);
        drive_cfg(16'h8005, 8'd0, 3'd2);
        exp_q.push_back(model(0, 20'h00000, 2));
        exp_q.push_back(model(2, 20'h00200, 2));
        exp_q.push_back(model(15, 20'h00F00, 2));
        pulse_start();
        drive_cfg(16'hFFFF, 8'd50, 3'd7);
        settle_n = 0; accum_n = 0; done_n = 0; onehot_bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (dbg_state == 2'd1) settle_n++;
            if (dbg_state == 2'd2) accum_n++;
            if (sweep.done) done_n++;
            if ((sweep.en_pm & (sweep.en_pm - 16'd1)) != 16'd0) onehot_bad++;
            sweep.start = (c == 5);
            cyc();
        end
        sweep.start = 1'b0;
        chk("t2_settle_cycles", 32'(settle_n), 32'd3);
        chk("t2_accum_cycles", 32'(accum_n), 32'd12);
        chk("t2_done_pulses", 32'(done_n), 32'd1);
        chk("t2_onehot", 32'(onehot_bad), 32'd0);
        chk("t2_all_results", 32'(exp_q.size()), 32'd0);

        // n=7 full-scale on slice 3
        sweep.pm_out[3] = 20'hFFFFF;
        drive_cfg(16'h0008, 8'd1, 3'd7);
        exp_q.push_back(model(3, 20'hFFFFF, 7));
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (sweep.done) seen = 1'b1;
            else cyc();
        end
        chk("t3_done_seen", 32'(seen), 32'd1);
        chk("t3_all_results", 32'(exp_q.size()), 32'd0);
        cyc();

        // Back-pressure: ready low for 10 cycles
        sweep.pm_out[1] = 20'hABCDE;
        sweep.result_ready = 1'b0;
        drive_cfg(16'h0002, 8'd2, 3'd1);
        exp_q.push_back(model(1, 20'hABCDE, 1));
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (sweep.result_valid) seen = 1'b1;
            else cyc();
        end
        chk("t4_valid_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("t4_hold_valid", 32'(sweep.result_valid), 32'd1);
            chk("t4_hold_idx", 32'(sweep.result_idx), 32'd1);
            chk("t4_hold_data", 32'(sweep.result_data), 32'hABCDE);
            chk("t4_hold_en_pm", 32'(sweep.en_pm), 32'd0);
            cyc();
        end
        sweep.result_ready = 1'b1;
        cyc();
        chk("t4_done", 32'(sweep.done), 32'd1);
        chk("t4_valid_cleared", 32'(sweep.result_valid), 32'd0);
        chk("t4_all_results", 32'(exp_q.size()), 32'd0);
        cyc();

        // Abort during ACCUM of slice 2
        sweep.pm_out[0] = 20'h00ABC;
        drive_cfg(16'h0005, 8'd1, 3'd3);
        exp_q.push_back(model(0, 20'h00ABC, 3));
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (dbg_state == 2'd2 && sweep.en_pm == 16'h0004) seen = 1'b1;
            else cyc();
        end
        chk("t5_accum2_seen", 32'(seen), 32'd1);
        sweep.abort = 1'b1;
        cyc();
        sweep.abort = 1'b0;
        chk("t5_abort_state", 32'(dbg_state), ST_IDLE);
        chk("t5_abort_en_pm", 32'(sweep.en_pm), 32'd0);
        chk("t5_abort_busy", 32'(sweep.busy), 32'd0);
        chk("t5_abort_valid", 32'(sweep.result_valid), 32'd0);
        chk("t5_abort_no_done", 32'(sweep.done), 32'd0);
        cyc();
        chk("t5_abort_no_done2", 32'(sweep.done), 32'd0);
        chk("t5_all_results", 32'(exp_q.size()), 32'd0);
        drive_cfg(16'h0000, 8'd3, 3'd0);
        pulse_start();
        chk("t5_empty_done", 32'(sweep.done), 32'd1);
        chk("t5_empty_busy", 32'(sweep.busy), 32'd0);
        chk("t5_empty_state", 32'(dbg_state), ST_IDLE);
        cyc();
        chk("t5_empty_done_once", 32'(sweep.done), 32'd0);
        // abort alone in IDLE
        sweep.abort = 1'b1;
        cyc();
        sweep.abort = 1'b0;
        chk("t5_idle_abort_state", 32'(dbg_state), ST_IDLE);
        chk("t5_idle_abort_done", 32'(sweep.done), 32'd0);
        // start together with abort
        drive_cfg(16'h0001, 8'd1, 3'd0);
        sweep.start = 1'b1;
        sweep.abort = 1'b1;
        cyc();
        sweep.start = 1'b0;
        sweep.abort = 1'b0;
        chk("t5_start_abort_busy", 32'(sweep.busy), 32'd0);
        chk("t5_start_abort_state", 32'(dbg_state), ST_IDLE);
        chk("t5_start_abort_en_pm", 32'(sweep.en_pm), 32'd0);
        cyc();

        // Asynchronous reset mid-SETTLE, then start on first edge after release
        drive_cfg(16'h0001, 8'd20, 3'd0);
        pulse_start();
        cyc();
        chk("t6_pre_state", 32'(dbg_state), ST_SETTLE);
        chk("t6_pre_en_pm", 32'(sweep.en_pm), 32'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_state", 32'(dbg_state), ST_IDLE);
        chk("t6_rst_en_pm", 32'(sweep.en_pm), 32'd0);
        chk("t6_rst_busy", 32'(sweep.busy), 32'd0);
        chk("t6_rst_valid_done", 32'({sweep.result_valid, sweep.done}), 32'd0);
        chk("t6_rst_idx_data", 32'({sweep.result_idx, sweep.result_data}), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        sweep.pm_out[1] = 20'h00777;
        drive_cfg(16'h0002, 8'd0, 3'd0);
        exp_q.push_back(model(1, 20'h00777, 0));
        pulse_start();
        chk("t6_restart_state", 32'(dbg_state), ST_SETTLE);
        chk("t6_restart_en_pm", 32'(sweep.en_pm), 32'h0002);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (sweep.done) seen = 1'b1;
            else cyc();
        end
        chk("t6_done_seen", 32'(seen), 32'd1);
        chk("t6_all_results", 32'(exp_q.size()), 32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
